mat_slot_store: RTL and testbench

- Two-slot matrix storage. Sits directly upstream of the transposition stage and serves its read port.
- Write side: a row-major element stream loads a matrix of latched dimensions into a selected slot.
- Read side: answers (slot, row, col) requests with one-cycle registered latency.
- Exports per-slot valid flags and dimensions so the control path can drive slot_valid, m_sel and n_sel.

---
 rtl/mat_pkg.sv | 21 ++
 rtl/mat_slot_ram.sv | 24 ++
 rtl/mat_slot_store.sv | 232 +++++++++++++++++++++++
 tb/tb_mat_slot_store.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants and write-FSM encoding for the matrix slot store
package mat_pkg;

  localparam int MAT_DIM_WIDTH  = 3;
  localparam int MAT_DATA_WIDTH = 8;
  localparam int MAT_MAX_DIM    = 5;
  localparam int MAT_NUM_SLOTS  = 2;
  localparam int MAT_SLOT_DEPTH = MAT_MAX_DIM * MAT_MAX_DIM;
  localparam int MAT_DEPTH      = MAT_NUM_SLOTS * MAT_SLOT_DEPTH;
  localparam int MAT_ADDR_WIDTH = $clog2(MAT_DEPTH);

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
`ifdef MAT_SLOT_STORE_CLEAR_EN
    WR_CLEAR  = 2'd1,
`endif
    WR_LOAD   = 2'd2,
    WR_COMMIT = 2'd3
  } wr_state_e;

endpackage

// File: rtl/mat_slot_ram.sv
// rtl/mat_slot_ram.sv - simple dual-port RAM, registered read, old data on collision
module mat_slot_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 50,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both ports update with non-blocking writes, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mat_slot_store.sv
// rtl/mat_slot_store.sv - two-slot matrix store; MAT_SLOT_STORE_CLEAR_EN zero-fills a slot before load
module mat_slot_store
  import mat_pkg::*;
#(
  parameter int DIM_WIDTH  = MAT_DIM_WIDTH,
  parameter int DATA_WIDTH = MAT_DATA_WIDTH,
  parameter int MAX_DIM    = MAT_MAX_DIM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_start,
  input  logic                  wr_slot,
  input  logic [DIM_WIDTH-1:0]  wr_m,
  input  logic [DIM_WIDTH-1:0]  wr_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  wr_error,
  output logic [1:0]            slot_valid,
  output logic [DIM_WIDTH-1:0]  slot0_m,
  output logic [DIM_WIDTH-1:0]  slot0_n,
  output logic [DIM_WIDTH-1:0]  slot1_m,
  output logic [DIM_WIDTH-1:0]  slot1_n,
  input  logic                  rd_en,
  input  logic                  rd_slot_idx,
  input  logic [DIM_WIDTH-1:0]  rd_row_idx,
  input  logic [DIM_WIDTH-1:0]  rd_col_idx,
  output logic [DATA_WIDTH-1:0] rd_elem,
  output logic                  rd_elem_valid,
  output logic                  rd_oob
);

  localparam int SLOT_DEPTH = MAX_DIM * MAX_DIM;
  localparam int DEPTH      = MAT_NUM_SLOTS * SLOT_DEPTH;
  localparam int AW         = $clog2(DEPTH);
  localparam logic [DIM_WIDTH-1:0] MAX_DIM_V = DIM_WIDTH'(MAX_DIM);
  localparam logic [DIM_WIDTH-1:0] ONE_V     = DIM_WIDTH'(1);

  function automatic logic [AW-1:0] elem_addr(input logic slot,
                                              input logic [DIM_WIDTH-1:0] row,
                                              input logic [DIM_WIDTH-1:0] col);
    return AW'(slot) * AW'(SLOT_DEPTH) + AW'(row) * AW'(MAX_DIM) + AW'(col);
  endfunction

  wr_state_e             state_q, state_d;
  logic                  slot_q;
  logic [DIM_WIDTH-1:0]  m_q, n_q, row_q, col_q;
  logic                  busy_q, done_q, error_q;
  logic [1:0]            slot_valid_q;
  logic [DIM_WIDTH-1:0]  s0_m_q, s0_n_q, s1_m_q, s1_n_q;

  logic                  legal, start_ok, start_bad, beat, commit;
  logic                  row_last, col_last;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

`ifdef MAT_SLOT_STORE_CLEAR_EN
  localparam int CW = $clog2(SLOT_DEPTH);
  logic [CW-1:0] clear_cnt_q;
  logic          clearing;
`endif

  assign legal    = (wr_m != '0) && (wr_n != '0) && (wr_m <= MAX_DIM_V) && (wr_n <= MAX_DIM_V);
  assign row_last = (row_q == m_q - ONE_V);
  assign col_last = (col_q == n_q - ONE_V);

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    beat      = 1'b0;
    commit    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = elem_addr(slot_q, row_q, col_q);
    ram_wdata = wr_data;
    wr_ready  = 1'b0;
`ifdef MAT_SLOT_STORE_CLEAR_EN
    clearing  = 1'b0;
`endif
    case (state_q)
      WR_IDLE: begin
        if (wr_start) begin
          if (legal) begin
            start_ok = 1'b1;
`ifdef MAT_SLOT_STORE_CLEAR_EN
            state_d  = WR_CLEAR;
`else
            state_d  = WR_LOAD;
`endif
          end else begin
            start_bad = 1'b1;
          end
        end
      end
`ifdef MAT_SLOT_STORE_CLEAR_EN
      WR_CLEAR: begin
        clearing  = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = AW'(slot_q) * AW'(SLOT_DEPTH) + AW'(clear_cnt_q);
        ram_wdata = '0;
        if (clear_cnt_q == CW'(SLOT_DEPTH - 1)) state_d = WR_LOAD;
      end
`endif
      WR_LOAD: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          beat   = 1'b1;
          ram_we = 1'b1;
          if (row_last && col_last) state_d = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        commit  = 1'b1;
        state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WR_IDLE;
      slot_q       <= 1'b0;
      m_q          <= '0;
      n_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      slot_valid_q <= '0;
      s0_m_q       <= '0;
      s0_n_q       <= '0;
      s1_m_q       <= '0;
      s1_n_q       <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= commit;
      error_q <= start_bad;
      if (start_ok) begin
        slot_q                <= wr_slot;
        m_q                   <= wr_m;
        n_q                   <= wr_n;
        row_q                 <= '0;
        col_q                 <= '0;
        busy_q                <= 1'b1;
        slot_valid_q[wr_slot] <= 1'b0;
      end
      if (beat) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + ONE_V;
        end else begin
          col_q <= col_q + ONE_V;
        end
      end
      if (commit) begin
        busy_q               <= 1'b0;
        slot_valid_q[slot_q] <= 1'b1;
        if (slot_q) begin
          s1_m_q <= m_q;
          s1_n_q <= n_q;
        end else begin
          s0_m_q <= m_q;
          s0_n_q <= n_q;
        end
      end
    end
  end

`ifdef MAT_SLOT_STORE_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) clear_cnt_q <= '0;
    else if (clearing)   clear_cnt_q <= clear_cnt_q + CW'(1);
  end
`endif

  assign wr_busy    = busy_q;
  assign wr_done    = done_q;
  assign wr_error   = error_q;
  assign slot_valid = slot_valid_q;
  assign slot0_m    = s0_m_q;
  assign slot0_n    = s0_n_q;
  assign slot1_m    = s1_m_q;
  assign slot1_n    = s1_n_q;

  // A slot being restarted this edge is already treated as invalid by the read port.
  logic [1:0]            clear_mask, slot_live;
  logic [DIM_WIDTH-1:0]  rd_m, rd_n;
  logic                  rd_oob_now;
  logic                  rd_valid_q, rd_oob_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign clear_mask = start_ok ? (wr_slot ? 2'b10 : 2'b01) : 2'b00;
  assign slot_live  = slot_valid_q & ~clear_mask;
  assign rd_m       = rd_slot_idx ? s1_m_q : s0_m_q;
  assign rd_n       = rd_slot_idx ? s1_n_q : s0_n_q;
  assign rd_oob_now = !slot_live[rd_slot_idx] || (rd_row_idx >= rd_m) || (rd_col_idx >= rd_n);

  // rd_oob_q resets high so rd_elem reads 0 until the first in-bounds read lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b1;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_oob_q <= rd_oob_now;
    end
  end

  assign rd_elem_valid = rd_valid_q;
  assign rd_oob        = rd_valid_q & rd_oob_q;
  assign rd_elem       = rd_oob_q ? '0 : ram_rdata;

  mat_slot_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en && !rd_oob_now),
    .raddr (elem_addr(rd_slot_idx, rd_row_idx, rd_col_idx)),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mat_slot_store.sv
// tb/tb_mat_slot_store.sv - scoreboard bench for mat_slot_store
module tb_mat_slot_store;
  import mat_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_start = 1'b0, wr_slot = 1'b0, wr_valid = 1'b0;
  logic [2:0] wr_m = '0, wr_n = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, wr_busy, wr_done, wr_error;
  logic [1:0] slot_valid;
  logic [2:0] slot0_m, slot0_n, slot1_m, slot1_n;
  logic       rd_en = 1'b0, rd_slot_idx = 1'b0;
  logic [2:0] rd_row_idx = '0, rd_col_idx = '0;
  logic [7:0] rd_elem;
  logic       rd_elem_valid, rd_oob;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_mem [2][5][5];
  logic [1:0] model_valid = '0;
  logic [2:0] model_m [2] = '{3'd0, 3'd0};
  logic [2:0] model_n [2] = '{3'd0, 3'd0};
  logic [8:0] exp_q [$];
  logic       pend_rd = 1'b0;

  mat_slot_store dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_slot(wr_slot), .wr_m(wr_m), .wr_n(wr_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_error(wr_error),
    .slot_valid(slot_valid), .slot0_m(slot0_m), .slot0_n(slot0_n),
    .slot1_m(slot1_m), .slot1_n(slot1_n),
    .rd_en(rd_en), .rd_slot_idx(rd_slot_idx), .rd_row_idx(rd_row_idx),
    .rd_col_idx(rd_col_idx), .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid),
    .rd_oob(rd_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected read results are taken from the committed-state model at the request edge.
  always @(posedge clk) begin
    if (rst) begin
      pend_rd <= 1'b0;
    end else begin
      pend_rd <= rd_en;
      if (rd_en) begin
        if (!model_valid[rd_slot_idx] || rd_row_idx >= model_m[rd_slot_idx] ||
            rd_col_idx >= model_n[rd_slot_idx])
          exp_q.push_back({1'b1, 8'h00});
        else
          exp_q.push_back({1'b0, model_mem[rd_slot_idx][rd_row_idx][rd_col_idx]});
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (pend_rd) begin
      check("rd_valid", rd_elem_valid, 1);
      if (exp_q.size() == 0) begin
        check("rd_queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rd_elem", rd_elem, e[7:0]);
        check("rd_oob", rd_oob, e[8]);
      end
    end else begin
      check("rd_idle_valid", rd_elem_valid, 0);
      check("rd_idle_oob", rd_oob, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_slots(input string tag);
    check({tag, "_slot_valid"}, slot_valid, model_valid);
    check({tag, "_s0m"}, slot0_m, model_m[0]);
    check({tag, "_s0n"}, slot0_n, model_n[0]);
    check({tag, "_s1m"}, slot1_m, model_m[1]);
    check({tag, "_s1n"}, slot1_n, model_n[1]);
  endtask

  task automatic load(input logic slot, input logic [2:0] m, input logic [2:0] n, input logic [7:0] base);
    wr_start = 1'b1; wr_slot = slot; wr_m = m; wr_n = n;
    model_valid[slot] = 1'b0;
    tick();
    wr_start = 1'b0;
    check("load_busy", wr_busy, 1);
`ifdef MAT_SLOT_STORE_CLEAR_EN
    repeat (MAT_SLOT_DEPTH) begin
      check("clear_ready", wr_ready, 0);
      tick();
    end
`endif
    for (int k = 0; k < int'(m) * int'(n); k++) begin
      check("load_ready", wr_ready, 1);
      check("load_done_early", wr_done, 0);
      wr_valid = 1'b1;
      wr_data  = base + 8'(k);
      tick();
    end
    wr_valid = 1'b0;
    check("commit_ready", wr_ready, 0);
    check("commit_done_early", wr_done, 0);
    tick();
    check("wr_done", wr_done, 1);
    check("busy_after_commit", wr_busy, 0);
    for (int r = 0; r < int'(m); r++)
      for (int c = 0; c < int'(n); c++)
        model_mem[slot][r][c] = base + 8'(r * int'(n) + c);
    model_m[slot] = m;
    model_n[slot] = n;
    model_valid[slot] = 1'b1;
    check_slots("after_load");
    tick();
    check("done_pulse_end", wr_done, 0);
  endtask

  task automatic rd(input logic s, input logic [2:0] r, input logic [2:0] c);
    rd_en = 1'b1; rd_slot_idx = s; rd_row_idx = r; rd_col_idx = c;
    tick();
  endtask

  logic [2:0] bad_m [3] = '{3'd0, 3'd2, 3'd6};
  logic [2:0] bad_n [3] = '{3'd3, 3'd6, 3'd2};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", wr_ready, 0);
    check("rst_busy", wr_busy, 0);
    check("rst_done", wr_done, 0);
    check("rst_error", wr_error, 0);
    check("rst_elem", rd_elem, 0);
    check_slots("rst");
    rst = 1'b0;
    tick();

    load(1'b0, 3'd2, 3'd3, 8'd1);

    rd(1'b0, 3'd1, 3'd2);
    rd(1'b0, 3'd0, 3'd1);
    rd(1'b0, 3'd2, 3'd0);
    rd(1'b1, 3'd0, 3'd0);
    rd(1'b0, 3'd1, 3'd2);
    rd_en = 1'b0;
    tick();
    check("rd_hold", rd_elem, 8'd6);

    for (int i = 0; i < 3; i++) begin
      wr_start = 1'b1; wr_slot = 1'b1; wr_m = bad_m[i]; wr_n = bad_n[i];
      tick();
      wr_start = 1'b0;
      check("err_pulse", wr_error, 1);
      check("err_busy", wr_busy, 0);
      check_slots("err");
      tick();
      check("err_pulse_end", wr_error, 0);
    end

    rd_en = 1'b1; rd_slot_idx = 1'b0; rd_row_idx = 3'd0; rd_col_idx = 3'd0;
    load(1'b0, 3'd1, 3'd1, 8'hA5);
    tick();
    rd_en = 1'b0;
    tick();

    wr_start = 1'b1; wr_slot = 1'b1; wr_m = 3'd2; wr_n = 3'd2;
    model_valid[1] = 1'b0;
    tick();
    wr_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h70 + 8'(k);
      tick();
    end
    wr_valid = 1'b0;
    rst = 1'b1;
    model_valid = '0;
    model_m = '{3'd0, 3'd0};
    model_n = '{3'd0, 3'd0};
    tick();
    rst = 1'b0;
    check("midrst_busy", wr_busy, 0);
    check("midrst_ready", wr_ready, 0);
    check_slots("midrst");
    tick();

    load(1'b1, 3'd2, 3'd2, 8'h10);
    rd(1'b1, 3'd0, 3'd0);
    rd(1'b1, 3'd0, 3'd1);
    rd(1'b1, 3'd1, 3'd0);
    rd(1'b1, 3'd1, 3'd1);
    rd(1'b1, 3'd1, 3'd2);
    rd(1'b0, 3'd0, 3'd0);
    rd_en = 1'b0;
    repeat (2) tick();
    check("rd_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
